// File: rtl/sipo_lsb_deser.sv
// LSB-first serial-in/parallel-out deserializer with a registered valid/ready output and sticky overrun.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per frame and the par_err output.
module sipo_lsb_deser #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic             sof,
   input  logic             sin,
   input  logic             out_ready,
   input  logic             clr,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             ovf
`ifdef SIPO_PARITY_EN
   ,
   output logic             par_err
`endif
);

`ifdef SIPO_PARITY_EN
   localparam int LAST_IDX = WIDTH;
`else
   localparam int LAST_IDX = WIDTH - 1;
`endif
   localparam int CNT_W = $clog2(LAST_IDX + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             ovf_q, ovf_d;
   logic             complete;
   logic             ovf_set;
   logic [WIDTH-1:0] word_done;
`ifdef SIPO_PARITY_EN
   logic             par_err_q, par_err_d;
   logic             word_perr;
`endif

   // Serial capture path: a sof with enb always restarts, even on what would be the completing bit.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      complete = 1'b0;
      if (enb) begin
         if (sof) begin
            shift_d    = '0;
            shift_d[0] = sin;
            cnt_d      = CNT_W'(1);
            state_d    = ST_SHIFT;
         end else if (state_q == ST_SHIFT) begin
            if (cnt_q == CNT_W'(LAST_IDX)) begin
               complete = 1'b1;
               cnt_d    = '0;
               shift_d  = '0;
               state_d  = ST_IDLE;
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (cnt_q == CNT_W'(i)) shift_d[i] = sin;
               end
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

`ifdef SIPO_PARITY_EN
   // Completion happens on the parity edge: data bits are already in shift_q, sin is the parity bit.
   assign word_done = shift_q;
   assign word_perr = (^shift_q) ^ sin;
`else
   // Completion happens on bit WIDTH-1, which is still on sin.
   assign word_done = {sin, shift_q[WIDTH-2:0]};
`endif

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      ovf_set     = 1'b0;
`ifdef SIPO_PARITY_EN
      par_err_d   = par_err_q;
`endif
      if (complete) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = word_done;
            out_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
            par_err_d   = word_perr;
`endif
         end else begin
            ovf_set = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
`ifdef SIPO_PARITY_EN
         par_err_d   = 1'b0;
`endif
      end
      // Set beats clear on the same edge.
      ovf_d = ovf_set | (ovf_q & ~clr);
   end

   // NOTE: state uses non-blocking assignments; the shift register is reset too so a mid-frame reset leaves no stale bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef SIPO_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
`ifdef SIPO_PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;
`ifdef SIPO_PARITY_EN
   assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_sipo_lsb_deser.sv
// Self-checking bench for sipo_lsb_deser: directed scenarios followed by random traffic against a
// bit-queue reference model. Honours SIPO_PARITY_EN the same way as the design.
module tb_sipo_lsb_deser;
   localparam int W = 4;
`ifdef SIPO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enb = 1'b0;
   logic         sof = 1'b0;
   logic         sin = 1'b0;
   logic         out_ready = 1'b0;
   logic         clr = 1'b0;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         ovf;
`ifdef SIPO_PARITY_EN
   logic         par_err;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: received bits of the current frame plus the output-port view.
   bit           mbits[$];
   bit           m_in_frame = 1'b0;
   logic [W-1:0] m_data     = '0;
   bit           m_valid    = 1'b0;
   bit           m_ovf      = 1'b0;
   bit           m_perr     = 1'b0;

   sipo_lsb_deser #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .enb       (enb),
      .sof       (sof),
      .sin       (sin),
      .out_ready (out_ready),
      .clr       (clr),
      .out_data  (out_data),
      .out_valid (out_valid),
      .ovf       (ovf)
`ifdef SIPO_PARITY_EN
      ,
      .par_err   (par_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      mbits.delete();
      m_in_frame = 1'b0;
      m_data     = '0;
      m_valid    = 1'b0;
      m_ovf      = 1'b0;
      m_perr     = 1'b0;
   endtask

   task automatic model_edge(input bit en, input bit sf, input bit si, input bit rd, input bit cl);
      bit           done;
      bit           set;
      bit           p;
      logic [W-1:0] w;
      done = 1'b0;
      set  = 1'b0;
      p    = 1'b0;
      w    = '0;
      if (en) begin
         if (sf) begin
            mbits.delete();
            mbits.push_back(si);
            m_in_frame = 1'b1;
         end else if (m_in_frame) begin
            mbits.push_back(si);
            if (mbits.size() == FL) begin
               done = 1'b1;
               foreach (mbits[i]) begin
                  if (i < W) w[i] = mbits[i];
                  p ^= mbits[i];
               end
               mbits.delete();
               m_in_frame = 1'b0;
            end
         end
      end
      if (done) begin
         if (!m_valid || rd) begin
            m_data  = w;
            m_valid = 1'b1;
            m_perr  = p;
         end else begin
            set = 1'b1;
         end
      end else if (m_valid && rd) begin
         m_valid = 1'b0;
         m_perr  = 1'b0;
      end
      m_ovf = set ? 1'b1 : (cl ? 1'b0 : m_ovf);
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".data"},  32'(out_data),  32'(m_data));
      check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
      check({tag, ".ovf"},   32'(ovf),       32'(m_ovf));
`ifdef SIPO_PARITY_EN
      check({tag, ".perr"},  32'(par_err),   32'(m_perr));
`endif
   endtask

   // One clock: drive at the falling edge, advance the model, sample 1 time unit after the rising edge.
   task automatic step(input string tag, input bit en, input bit sf, input bit si, input bit rd, input bit cl);
      @(negedge clk);
      enb = en; sof = sf; sin = si; out_ready = rd; clr = cl;
      model_edge(en, sf, si, rd, cl);
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic send_frame(input string tag, input logic [W-1:0] word, input bit rd);
      for (int i = 0; i < W; i++) step(tag, 1'b1, i == 0, word[i], rd, 1'b0);
`ifdef SIPO_PARITY_EN
      step(tag, 1'b1, 1'b0, ^word, rd, 1'b0);
`endif
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".data"},  32'(out_data),  32'h0);
      check({tag, ".valid"}, 32'(out_valid), 32'h0);
      check({tag, ".ovf"},   32'(ovf),       32'h0);
`ifdef SIPO_PARITY_EN
      check({tag, ".perr"},  32'(par_err),   32'h0);
`endif
   endtask

   initial begin
      bit sf, en;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // Basic frame 4'hB, consumed on the next edge.
      send_frame("t1", 4'hB, 1'b1);
      check("t1.data_b", 32'(out_data), 32'hB);
      check("t1.valid_hi", 32'(out_valid), 32'h1);
      step("t1.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t1.valid_lo", 32'(out_valid), 32'h0);

      // Overrun: second word dropped while the consumer stalls.
      send_frame("t2", 4'h3, 1'b0);
      send_frame("t2", 4'hC, 1'b0);
      check("t2.data_kept", 32'(out_data), 32'h3);
      check("t2.ovf_set", 32'(ovf), 32'h1);
      step("t2.clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t2.ovf_clr", 32'(ovf), 32'h0);
      step("t2.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t2.valid_lo", 32'(out_valid), 32'h0);

      // Frame 4'h5 with a 3-cycle enable gap (sof/sin toggled while disabled).
      step("t3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step("t3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("t3.gap", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step("t3.gap", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step("t3.gap", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("t3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
      step("t3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t3.not_yet", 32'(out_valid), 32'h0);
      step("t3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`else
      check("t3.not_yet", 32'(out_valid), 32'h0);
      step("t3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
      check("t3.data_5", 32'(out_data), 32'h5);
      check("t3.valid", 32'(out_valid), 32'h1);

      // Restart on bit 2: only the new frame 4'hE is delivered.
      step("t4", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step("t4", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame("t4", 4'hE, 1'b1);
      check("t4.data_e", 32'(out_data), 32'hE);
      check("t4.ovf", 32'(ovf), 32'h0);
      step("t4.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset mid-frame, then frame 4'h9.
      step("t5", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step("t5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("t5", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 check_zero("t5.in_rst");
      model_reset();
      @(negedge clk);
      enb = 1'b0;
      rst = 1'b0;
      send_frame("t5", 4'h9, 1'b1);
      check("t5.data_9", 32'(out_data), 32'h9);
      check("t5.valid", 32'(out_valid), 32'h1);

`ifdef SIPO_PARITY_EN
      // Parity: good then bad parity on word 4'h7.
      send_frame("t6.good", 4'h7, 1'b1);
      check("t6.good_perr", 32'(par_err), 32'h0);
      check("t6.good_data", 32'(out_data), 32'h7);
      for (int i = 0; i < W; i++) step("t6.bad", 1'b1, i == 0, 1'b1 ^ (i == W - 1), 1'b1, 1'b0);
      step("t6.bad", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t6.bad_perr", 32'(par_err), 32'h1);
      check("t6.bad_data", 32'(out_data), 32'h7);
`endif

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         en = ($urandom_range(0, 3) != 0);
         sf = m_in_frame ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
         step("rnd", en, sf, 1'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sipo_lsb_deser.md
# sipo_lsb_deser

Serial-in/parallel-out deserializer that consumes the LSB-first bit stream produced by the parallel-in/serial-out shifter and reassembles it into WIDTH-bit words. Frames start on a load/start strobe aligned with bit 0. Completed words are presented on a registered valid/ready output port. Overrun is flagged when the consumer stalls. It sits directly downstream of the PISO stage, on the same clock.

## Interface
- WIDTH, 4, data bits per frame (≥2)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- enb  in  1  bit-slot enable; the serial path advances only on edges where enb=1
- sof  in  1  start-of-frame strobe; sampled with enb=1 it marks the current sin as bit 0
- sin  in  1  serial data, LSB first
- out_ready  in  1  consumer accepts out_data when out_valid=1 and out_ready=1
- clr  in  1  synchronous clear of sticky ovf
- out_data  out  WIDTH  assembled word, bit i = i-th received bit
- out_valid  out  1  out_data holds an unconsumed word
- ovf  out  1  sticky overrun flag
- par_err  out  1  only with SIPO_PARITY_EN; see Configuration

## Operation
- States: IDLE (no frame), SHIFT (frame in progress, bit counter cnt 0..WIDTH-1), plus an independent output register (out_data, out_valid).
- IDLE: edge with enb=1 and sof=1 → capture sin into shift bit 0, cnt=1, go SHIFT. WIDTH=… sof=0 is ignored.
- SHIFT: edge with enb=1 → capture sin at position cnt, cnt+1. On capture of bit WIDTH-1 → word complete, return to IDLE.
- sof=1 during SHIFT (enb=1): partial word discarded with no output and no flag, that bit becomes bit 0 of a new frame, cnt=1.
- sof=1 on the completing bit (cnt=WIDTH-1): treated as restart, and the current word is not delivered.
- enb=0: shift register, cnt and state hold. sof and sin are ignored. Output handshake still operates.
- Word completion:
  - If out_valid=0, or out_valid=1 and out_ready=1 on the same edge → load out_data, and out_valid is 1.
  - If out_valid=1 and out_ready=0 → new word dropped, out_data unchanged, ovf←1.
- Handshake: out_valid=1 and out_ready=1 with no completion → out_valid←0. out_data holds its last value.
- ovf: set by overrun, cleared by clr. Set wins over clr on the same edge.
- Reset (any time, including mid-frame): state IDLE, cnt=0, shift register 0, out_data=0, out_valid=0, ovf=0, par_err=0. The partial frame is lost.

## Timing
- All outputs registered. No combinational path from inputs to outputs.
- Latency: out_valid and out_data update on the same edge that captures bit WIDTH-1. They are visible immediately after that edge.
- Minimum frame = WIDTH enabled edges (WIDTH+1 with parity). Back-to-back frames are supported: sof may arrive on the enabled edge right after completion.
- out_valid falls on the edge where out_ready=1 is sampled with out_valid=1, unless a new word loads on that edge.
- ovf rises on the edge of the dropped completion.

## Configuration
- SIPO_PARITY_EN defined:
  - Each frame carries one extra even-parity bit after bit WIDTH-1. cnt runs to WIDTH.
  - Completion occurs on the parity edge.
  - par_err is loaded together with out_data: 1 if XOR(data bits, parity bit)=1. It is cleared when the word is consumed without a replacement.
  - On overrun, par_err is unchanged.
- SIPO_PARITY_EN undefined: frames are exactly WIDTH bits. The par_err port is absent.

## Test plan
- WIDTH=4, out_ready=1, sof on the first edge, sin=1,1,0,1 over 4 enabled edges → out_data=4'hB and out_valid=1 after the 4th edge, out_valid=0 one edge later.
- Two back-to-back frames 4'h3 then 4'hC with out_ready=0 → out_data stays 4'h3, out_valid=1, ovf=1. Then clr=1 → ovf=0. out_ready=1 → out_valid=0.
- Frame 4'h5 with enb=0 for 3 cycles between bits 1 and 2 → out_data=4'h5. Completion is delayed by exactly 3 cycles.
- sof reasserted on bit 2 of a frame, then sin=0,1,1,1 → only 4'hE delivered. No ovf.
- rst pulsed (asynchronously, mid-cycle) after bit 2, then a full frame 4'h9 → nothing delivered before the reset, 4'h9 delivered after. All outputs 0 during reset.
- With SIPO_PARITY_EN: frame 4'h7 with parity bit 1 → par_err=0. Frame 4'h7 with parity bit 0 → par_err=1. In both cases out_data=4'h7.
